// File: rtl/fft_arb_pkg.sv
// rtl/fft_arb_pkg.sv - shared state enum, width helpers and defaults for fft_frame_arbiter
package fft_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int DEF_FRAME_LEN   = 32;
  localparam int DEF_TIMEOUT_CYC = 256;

  // Channel index width; at least one bit so a 2-channel build still has a real vector
  function automatic int idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  // Beat counter width; FRAME_LEN is a power of two so the counter wraps exactly at a frame
  function automatic int cnt_w(input int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction

  // Stall counter width; must hold TIMEOUT_CYC-1
  function automatic int stall_w(input int timeout_cyc);
    return (timeout_cyc <= 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/fft_frame_arbiter_if.sv
// rtl/fft_frame_arbiter_if.sv - channel-side and FFT-side stream bundle of fft_frame_arbiter
interface fft_frame_arbiter_if
  import fft_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = idx_w(NUM_CH);

  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH-1:0]            grant;
  logic [DATA_WIDTH-1:0]        m_data;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready;
  logic [IW-1:0]                m_chan;
  logic                         busy;
  logic                         err;

  modport master (
    input  ch_req, ch_data, ch_valid, m_ready,
    output ch_ready, grant, m_data, m_valid, m_last, m_chan, busy, err
  );

  modport slave (
    output ch_req, ch_data, ch_valid, m_ready,
    input  ch_ready, grant, m_data, m_valid, m_last, m_chan, busy, err
  );

endinterface

// File: rtl/fft_frame_arbiter_rr_pick.sv
// rtl/fft_frame_arbiter_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module rr_pick
  import fft_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic [NUM_CH-1:0] win,
  output logic [IW-1:0]     idx,
  output logic              any
);

  int cand;

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr overwrites the rest
  always_comb begin
    win  = '0;
    idx  = '0;
    cand = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (req[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// rtl/fft_frame_arbiter.sv - frame-granular round-robin arbiter feeding the FFT input stream (optional stall abort: FFT_ARB_TIMEOUT_EN)
module fft_frame_arbiter
  import fft_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  fft_frame_arbiter_if.master  bus
);

  localparam int IW = idx_w(NUM_CH);
  localparam int CW = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

  arb_state_e        state_q;
  logic [NUM_CH-1:0] grant_q;
  logic [IW-1:0]     chan_q;
  logic [IW-1:0]     rr_q;
  logic [CW-1:0]     cnt_q;

  logic [NUM_CH-1:0]     pick_win;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  accept;
  logic [IW-1:0]         rr_next;

  rr_pick #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
    .req    (bus.ch_req),
    .rr_ptr (rr_q),
    .win    (pick_win),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the granted lane; chan_q is stable for the whole frame
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_q == IW'(i)) begin
        sel_data  = bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = bus.ch_valid[i];
      end
    end
  end

  assign xfer     = (state_q == XFER);
  assign accept   = bus.m_valid && bus.m_ready;
  assign rr_next  = (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;

  assign bus.m_data   = xfer ? sel_data : '0;
  assign bus.m_valid  = xfer && sel_valid;
  assign bus.m_last   = bus.m_valid && (cnt_q == LAST_BEAT);
  // grant_q is one-hot only in XFER, so it gates ready to the owning channel
  assign bus.ch_ready = grant_q & {NUM_CH{bus.m_ready}};
  assign bus.grant    = grant_q;
  assign bus.m_chan   = chan_q;
  assign bus.busy     = (state_q != IDLE);

`ifdef FFT_ARB_TIMEOUT_EN
  localparam int SW = stall_w(TIMEOUT_CYC);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYC - 1);

  logic [SW-1:0] stall_q;
  logic          err_q;

  assign bus.err = err_q;
`else
  // No stall watchdog in this build, so err can never fire
  assign bus.err = (TIMEOUT_CYC < 0);
`endif

  // Arbitration FSM: pick in IDLE, count beats in XFER, one grant-free GAP cycle between frames
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      chan_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
`ifdef FFT_ARB_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef FFT_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_win;
            chan_q  <= pick_idx;
            cnt_q   <= '0;
            state_q <= XFER;
`ifdef FFT_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
          end
        end
        XFER: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
`ifdef FFT_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (cnt_q == LAST_BEAT) begin
              state_q <= GAP;
              grant_q <= '0;
              rr_q    <= rr_next;
            end
          end
`ifdef FFT_ARB_TIMEOUT_EN
          // Abort a stuck frame and skip past the stalled channel
          else if (stall_q == STALL_MAX) begin
            err_q   <= 1'b1;
            state_q <= GAP;
            grant_q <= '0;
            rr_q    <= rr_next;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// tb/tb_fft_frame_arbiter.sv - scoreboard bench for fft_frame_arbiter (FFT_ARB_TIMEOUT_EN selects abort expectations)
module tb_fft_frame_arbiter;
  import fft_arb_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int FL     = 32;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  fft_frame_arbiter #(
    .NUM_CH      (NUM_CH),
    .DATA_WIDTH  (DW),
    .FRAME_LEN   (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [27:0] src_cnt [NUM_CH] = '{default: '0};
  logic [27:0] exp_cnt [NUM_CH] = '{default: '0};
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;

  // Each source emits {channel, sequence}; the sequence advances on every handshake
  for (genvar g = 0; g < NUM_CH; g++) begin : g_src
    assign bus.ch_data[g*DW +: DW] = {4'(g), src_cnt[g]};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_valid[i] && bus.ch_ready[i]) src_cnt[i] <= src_cnt[i] + 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got chan %0d data %0h, expected no beat", bus.m_chan, bus.m_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_chan", 64'(bus.m_chan), 64'(mon_e.chan));
        check("beat_data", 64'(bus.m_data), 64'(mon_e.data));
        check("beat_last", 64'(bus.m_last), 64'(mon_e.last));
      end
    end
  end

  task automatic push_frame(input int ch, input int n, input bit full);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.chan = 2'(ch);
      b.data = {4'(ch), exp_cnt[ch]};
      b.last = full && (k == FL - 1);
      exp_cnt[ch] = exp_cnt[ch] + 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max);
    int n;
    n = 0;
    while (bus.grant == '0 && n < max) begin step(); n++; end
    if (bus.grant == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: got no grant after %0d cycles, expected a grant", max);
    end
  endtask

  task automatic wait_gap(input int max);
    int n;
    n = 0;
    while (bus.grant != '0 && n < max) begin step(); n++; end
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int prev;
    prev = 0;
    bus.ch_req   = '0;
    bus.ch_valid = 4'hF;
    bus.m_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    check("rst_grant",    64'(bus.grant),    0);
    check("rst_ch_ready", 64'(bus.ch_ready), 0);
    check("rst_m_valid",  64'(bus.m_valid),  0);
    check("rst_m_last",   64'(bus.m_last),   0);
    check("rst_m_data",   64'(bus.m_data),   0);
    check("rst_m_chan",   64'(bus.m_chan),   0);
    check("rst_busy",     64'(bus.busy),     0);
    check("rst_err",      64'(bus.err),      0);
    rst = 1'b0;

    // Single requester on channel 2
    bus.ch_req = 4'b0100;
    step();
    check("t1_grant", 64'(bus.grant), 64'b0100);
    check("t1_chan",  64'(bus.m_chan), 2);
    bus.ch_req = '0;
    push_frame(2, FL, 1'b1);
    repeat (FL - 1) step();
    check("t1_last_beat31", 64'(bus.m_last), 1);
    step();
    check("t1_gap_grant", 64'(bus.grant), 0);
    check("t1_gap_busy",  64'(bus.busy), 1);
    check("t1_gap_valid", 64'(bus.m_valid), 0);
    step();
    check("t1_idle_busy", 64'(bus.busy), 0);

    // rr_ptr is now 3, so channel 3 beats channels 0 and 1
    bus.ch_req = 4'b1011;
    step();
    check("t1b_grant", 64'(bus.grant), 64'b1000);
    bus.ch_req = '0;
    push_frame(3, FL, 1'b1);
    repeat (FL + 1) step();
    check("t1b_idle", 64'(bus.busy), 0);

    // All four requesting: order 0,1,2,3,0 with a 34-cycle period
    bus.ch_req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_grant(40);
      check("t2_grant", 64'(bus.grant), 64'(1) << order[f]);
      push_frame(order[f], FL, 1'b1);
      if (f > 0) check("t2_period", 64'(cyc - prev), FL + 2);
      prev = cyc;
      if (f == 4) bus.ch_req = '0;
      wait_gap(40);
      check("t2_frame_len", 64'(cyc - prev), FL);
      check("t2_gap_busy",  64'(bus.busy), 1);
    end
    step();
    check("t2_idle", 64'(bus.busy), 0);

    // Random valid/ready stalls on channel 1
    bus.ch_req = 4'b0010;
    step();
    check("t3_grant", 64'(bus.grant), 64'b0010);
    bus.ch_req = '0;
    push_frame(1, FL, 1'b1);
    for (int n = 0; n < 1500 && bus.busy; n++) begin
      bus.ch_valid[1] = 1'($urandom_range(0, 1));
      bus.m_ready     = 1'($urandom_range(0, 1));
      step();
    end
    bus.ch_valid = 4'hF;
    bus.m_ready  = 1'b1;
    check("t3_done", 64'(bus.busy), 0);

    // Reset at beat 15 of a channel-2 frame; rr_ptr was 2 and must return to 0
    bus.ch_req = 4'b0100;
    step();
    check("t5_grant", 64'(bus.grant), 64'b0100);
    bus.ch_req = '0;
    push_frame(2, 15, 1'b0);
    repeat (15) step();
    rst = 1'b1;
    bus.m_ready = 1'b0;
    step();
    bus.m_ready = 1'b1;
    #1;
    check("t5_grant_rst",  64'(bus.grant),    0);
    check("t5_ready_rst",  64'(bus.ch_ready), 0);
    check("t5_valid_rst",  64'(bus.m_valid),  0);
    check("t5_data_rst",   64'(bus.m_data),   0);
    check("t5_chan_rst",   64'(bus.m_chan),   0);
    check("t5_busy_rst",   64'(bus.busy),     0);
    rst = 1'b0;
    bus.ch_req = 4'b1010;
    step();
    check("t5_rearb_grant", 64'(bus.grant), 64'b0010);
    bus.ch_req = '0;
    push_frame(1, FL, 1'b1);
    repeat (FL + 1) step();
    check("t5_idle", 64'(bus.busy), 0);

    // ch_req[0] dropped at beat 10 while ch_req[3] rises
    bus.ch_req = 4'b0001;
    step();
    check("t4_grant0", 64'(bus.grant), 64'b0001);
    push_frame(0, FL, 1'b1);
    repeat (10) step();
    bus.ch_req = 4'b1000;
    repeat (FL - 10) step();
    check("t4_gap_grant", 64'(bus.grant), 0);
    check("t4_gap_busy",  64'(bus.busy), 1);
    step();
    check("t4_idle_busy", 64'(bus.busy), 0);
    step();
    check("t4_grant3", 64'(bus.grant), 64'b1000);
    bus.ch_req = '0;
    push_frame(3, FL, 1'b1);
    repeat (FL + 1) step();
    check("t4_idle", 64'(bus.busy), 0);

    // Stall channel 2 for TO cycles mid-frame with channel 3 waiting
    bus.ch_req = 4'b0100;
    step();
    check("t6_grant", 64'(bus.grant), 64'b0100);
    bus.ch_req = 4'b1000;
`ifdef FFT_ARB_TIMEOUT_EN
    push_frame(2, 5, 1'b0);
`else
    push_frame(2, FL, 1'b1);
`endif
    repeat (5) step();
    bus.ch_valid = 4'b1011;
    repeat (TO) step();
`ifdef FFT_ARB_TIMEOUT_EN
    check("t6_err_pulse", 64'(bus.err), 1);
    check("t6_abort_grant", 64'(bus.grant), 0);
    bus.ch_valid = 4'hF;
    step();
    check("t6_err_clear", 64'(bus.err), 0);
    check("t6_idle", 64'(bus.busy), 0);
    step();
`else
    check("t6_hold_grant", 64'(bus.grant), 64'b0100);
    check("t6_no_err", 64'(bus.err), 0);
    repeat (4) step();
    check("t6_hold_grant2", 64'(bus.grant), 64'b0100);
    check("t6_no_err2", 64'(bus.err), 0);
    bus.ch_valid = 4'hF;
    repeat (FL - 5) step();
    check("t6_gap_grant", 64'(bus.grant), 0);
    step();
    step();
`endif
    check("t6_next_grant", 64'(bus.grant), 64'b1000);
    bus.ch_req = '0;
    push_frame(3, FL, 1'b1);
    repeat (FL + 1) step();
    check("t6_end_idle", 64'(bus.busy), 0);

    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
